// File: rtl/krnl_cam_rtl_cam_pipe.sv
// CAM core: bulk/single key load and lowest-index search, 3-stage result pipe.
// Optional CAM_VALID_MASK_EN adds per-entry valid bits and UPDATE_ONE invalidate.
module krnl_cam_rtl_cam_pipe #(
  parameter int C_DATA_WIDTH  = 512,
  parameter int KEY_WIDTH     = 32,
  parameter int CAM_SIZE      = 256,
  parameter int INDEX_WIDTH   = $clog2(CAM_SIZE),
  parameter int DIVITION      = 4,
  parameter int OP_CODE_WIDTH = 3
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [OP_CODE_WIDTH-1:0] state,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic [C_DATA_WIDTH-1:0]  s_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [C_DATA_WIDTH-1:0]  m_tdata,
  output logic                     update_all_end
);

  localparam int LANES = C_DATA_WIDTH / KEY_WIDTH;
  localparam int SEG   = CAM_SIZE / DIVITION;
  localparam int SEGW  = (SEG > 1) ? $clog2(SEG) : 1;
  localparam logic [INDEX_WIDTH-1:0] LAST_WI =
    INDEX_WIDTH'(CAM_SIZE - LANES);

  typedef enum logic [1:0] {K_SRCH, K_ALL, K_ONE} kind_e;

  logic en, acc, op_all, op_srch, op_one, inv, wi_last;
  logic [KEY_WIDTH-1:0]   key;
  logic [INDEX_WIDTH-1:0] one_idx;
  logic [INDEX_WIDTH-1:0] wi_q;
  logic [KEY_WIDTH-1:0]   mem_q [CAM_SIZE];

  assign en       = !m_tvalid || m_tready;
  assign s_tready = en;
  assign acc      = s_tvalid && en;
  assign op_all   = state == OP_CODE_WIDTH'(1);
  assign op_srch  = state == OP_CODE_WIDTH'(2);
  assign op_one   = state == OP_CODE_WIDTH'(3);
  assign key      = s_tdata[KEY_WIDTH-1:0];
  assign one_idx  = s_tdata[KEY_WIDTH +: INDEX_WIDTH];
  assign wi_last  = wi_q == LAST_WI;
  assign update_all_end = aresetn && acc && op_all && wi_last;

`ifdef CAM_VALID_MASK_EN
  logic [CAM_SIZE-1:0] vld_q;
  assign inv = s_tdata[KEY_WIDTH+INDEX_WIDTH];

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      vld_q <= '0;
    end else if (acc && op_all) begin
      for (int k = 0; k < LANES; k++)
        vld_q[wi_q + INDEX_WIDTH'(k)] <= 1'b1;
    end else if (acc && op_one) begin
      vld_q[one_idx] <= !inv;
    end
  end
`else
  assign inv = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < CAM_SIZE; i++)
        mem_q[i] <= '0;
    end else if (acc && op_all) begin
      for (int k = 0; k < LANES; k++)
        mem_q[wi_q + INDEX_WIDTH'(k)] <=
          s_tdata[k*KEY_WIDTH +: KEY_WIDTH];
    end else if (acc && op_one && !inv) begin
      mem_q[one_idx] <= key;
    end
  end

  // Any non-bulk cycle rewinds the load pointer, so aborted loads restart.
  always_ff @(posedge aclk) begin
    if (!aresetn)
      wi_q <= '0;
    else if (!op_all)
      wi_q <= '0;
    else if (acc)
      wi_q <= wi_last ? '0 : wi_q + INDEX_WIDTH'(LANES);
  end

  logic [CAM_SIZE-1:0] match_d, match1_q;
  logic v1_d, v1_q, v2_q, m_tvalid_q;
  kind_e kind_d, kind1_q, kind2_q;
  logic [INDEX_WIDTH-1:0] idx1_q, idx2_q;

  always_comb begin
    match_d = '0;
    for (int i = 0; i < CAM_SIZE; i++) begin
`ifdef CAM_VALID_MASK_EN
      match_d[i] = (mem_q[i] == key) && vld_q[i];
`else
      match_d[i] = mem_q[i] == key;
`endif
    end
  end

  always_comb begin
    kind_d = K_SRCH;
    unique case (1'b1)
      op_all:  kind_d = K_ALL;
      op_one:  kind_d = K_ONE;
      default: kind_d = K_SRCH;
    endcase
  end

  assign v1_d = acc && (op_srch || op_one || (op_all && wi_last));

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      v1_q     <= 1'b0;
      kind1_q  <= K_SRCH;
      idx1_q   <= '0;
      match1_q <= '0;
    end else if (en) begin
      v1_q     <= v1_d;
      kind1_q  <= kind_d;
      idx1_q   <= one_idx;
      match1_q <= match_d;
    end
  end

  logic [DIVITION-1:0]           seg_hit_d, seg_hit2_q;
  logic [DIVITION-1:0][SEGW-1:0] seg_idx_d, seg_idx2_q;

  always_comb begin
    seg_hit_d = '0;
    seg_idx_d = '0;
    for (int d = 0; d < DIVITION; d++) begin
      for (int j = SEG - 1; j >= 0; j--) begin
        if (match1_q[d*SEG + j]) begin
          seg_hit_d[d] = 1'b1;
          seg_idx_d[d] = SEGW'(j);
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      v2_q       <= 1'b0;
      kind2_q    <= K_SRCH;
      idx2_q     <= '0;
      seg_hit2_q <= '0;
      seg_idx2_q <= '0;
    end else if (en) begin
      v2_q       <= v1_q;
      kind2_q    <= kind1_q;
      idx2_q     <= idx1_q;
      seg_hit2_q <= seg_hit_d;
      seg_idx2_q <= seg_idx_d;
    end
  end

  logic [INDEX_WIDTH-1:0]  hit_idx;
  logic [C_DATA_WIDTH-1:0] res_d, m_tdata_q;

  always_comb begin
    hit_idx = '0;
    for (int d = DIVITION - 1; d >= 0; d--) begin
      if (seg_hit2_q[d])
        hit_idx = INDEX_WIDTH'(d * SEG) + INDEX_WIDTH'(seg_idx2_q[d]);
    end
  end

  always_comb begin
    res_d = '0;
    unique case (kind2_q)
      K_ALL: res_d = C_DATA_WIDTH'(100);
      K_ONE: begin
        res_d[C_DATA_WIDTH-1]  = 1'b1;
        res_d[INDEX_WIDTH-1:0] = idx2_q;
      end
      default: begin
        if (|seg_hit2_q)
          res_d[INDEX_WIDTH:0] = {1'b0, hit_idx};
        else
          res_d[INDEX_WIDTH:0] = '1;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
    end else if (en) begin
      m_tvalid_q <= v2_q;
      if (v2_q)
        m_tdata_q <= res_d;
    end
  end

  assign m_tvalid = m_tvalid_q;
  assign m_tdata  = m_tdata_q;

endmodule

// File: tb/tb_krnl_cam_rtl_cam_pipe.sv
// Bench for krnl_cam_rtl_cam_pipe: directed table, corner sequences, random vs model.
module tb_krnl_cam_rtl_cam_pipe;
  localparam int DW = 512;
  localparam int KW = 32;
  localparam int N  = 256;
  localparam int IW = 8;
  localparam int LN = 16;
`ifdef CAM_VALID_MASK_EN
  localparam bit VM = 1'b1;
`else
  localparam bit VM = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [2:0]    state = 3'd0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] s_tdata = '0;
  logic          m_tvalid;
  logic          m_tready;
  logic [DW-1:0] m_tdata;
  logic          update_all_end;

  krnl_cam_rtl_cam_pipe dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .state          (state),
    .s_tvalid       (s_tvalid),
    .s_tready       (s_tready),
    .s_tdata        (s_tdata),
    .m_tvalid       (m_tvalid),
    .m_tready       (m_tready),
    .m_tdata        (m_tdata),
    .update_all_end (update_all_end)
  );

  always #5 aclk = ~aclk;

  int cmp = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    cmp++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: flat key array, valid flags, load pointer, result queue
  typedef struct {
    logic [DW-1:0] d;
    int            acc;
  } exp_t;

  logic [KW-1:0] mdl [N];
  bit            mvld [N];
  int            wi = 0;
  exp_t          exp_q [$];
  exp_t          e;
  logic [DW-1:0] out_log [$];
  int            out_cyc [$];
  int            end_cnt = 0;
  int            cyc = 0;
  int            last_stall = -1;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data;
  bit            saw_low = 0;
  bit            exp_end;
  int            rdy_mode = 0;

  function automatic logic [DW-1:0] srv(input int i);
    logic [DW-1:0] r;
    r = '0;
    r[IW:0] = 9'(i);
    return r;
  endfunction

  function automatic logic [DW-1:0] miss();
    logic [DW-1:0] r;
    r = '0;
    r[IW:0] = 9'h1FF;
    return r;
  endfunction

  function automatic logic [DW-1:0] ack1(input int i);
    logic [DW-1:0] r;
    r = '0;
    r[DW-1] = 1'b1;
    r[IW-1:0] = IW'(i);
    return r;
  endfunction

  function automatic logic [DW-1:0] srch(input logic [KW-1:0] k);
    for (int i = 0; i < N; i++)
      if (mdl[i] == k && (!VM || mvld[i])) return srv(i);
    return miss();
  endfunction

  function automatic logic [DW-1:0] mk(input logic [KW-1:0] k,
                                       input int idx, input bit iv);
    logic [DW-1:0] r;
    r = '0;
    r[KW-1:0] = k;
    r[KW +: IW] = IW'(idx);
    r[KW+IW] = iv;
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd512();
    logic [DW-1:0] r;
    for (int w = 0; w < DW/32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  always @(negedge aclk) begin
    cyc++;
    if (!aresetn) begin
      chk("end_in_reset", DW'(update_all_end), '0);
      for (int i = 0; i < N; i++) begin
        mdl[i] = '0;
        mvld[i] = 0;
      end
      wi = 0;
      exp_q.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", DW'(m_tvalid), DW'(1));
        chk("stall_data", m_tdata, prev_data);
      end
      chk("s_tready", DW'(s_tready), DW'(!m_tvalid || m_tready));
      if (!s_tready) saw_low = 1;
      if (update_all_end) end_cnt++;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          cmp++;
          errs++;
          $display("FAIL spurious: got %0h want none", m_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("result", m_tdata, e.d);
          if (last_stall < e.acc) chk("latency", DW'(cyc - e.acc), DW'(3));
          out_log.push_back(m_tdata);
          out_cyc.push_back(cyc);
        end
      end
      prev_stall = m_tvalid && !m_tready;
      if (prev_stall) begin
        last_stall = cyc;
        prev_data = m_tdata;
      end
      exp_end = 0;
      if (s_tvalid && s_tready) begin
        case (state)
          3'd1: begin
            for (int k = 0; k < LN; k++) begin
              mdl[wi+k] = s_tdata[k*KW +: KW];
              mvld[wi+k] = 1;
            end
            if (wi == N - LN) begin
              exp_end = 1;
              exp_q.push_back('{DW'(100), cyc});
              wi = 0;
            end else begin
              wi += LN;
            end
          end
          3'd2: exp_q.push_back('{srch(s_tdata[KW-1:0]), cyc});
          3'd3: begin
            int idx;
            idx = int'(s_tdata[KW +: IW]);
            if (VM && s_tdata[KW+IW]) begin
              mvld[idx] = 0;
            end else begin
              mdl[idx] = s_tdata[KW-1:0];
              mvld[idx] = 1;
            end
            exp_q.push_back('{ack1(idx), cyc});
          end
          default: ;
        endcase
      end
      if (state != 3'd1) wi = 0;
      chk("update_all_end", DW'(update_all_end), DW'(exp_end));
    end
  end

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = 1'b0;
        default: m_tready = ($urandom % 3) != 0;
      endcase
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    state = 3'd0;
    repeat (n) step();
  endtask

  task automatic send(input logic [2:0] st, input logic [DW-1:0] d);
    state = st;
    s_tdata = d;
    s_tvalid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge aclk);
      if (s_tready) begin
        step();
        s_tvalid = 1'b0;
        return;
      end
      step();
    end
    cmp++;
    errs++;
    $display("FAIL send_timeout: got s_tready=0 want 1");
    s_tvalid = 1'b0;
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rst_m_tvalid", DW'(m_tvalid), '0);
    chk("rst_m_tdata", m_tdata, '0);
    chk("rst_s_tready", DW'(s_tready), DW'(1));
    step();
  endtask

  task automatic bulk_load(input string nm);
    logic [DW-1:0] d;
    int e0;
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < LN; k++) d[k*KW +: KW] = KW'(b*LN + k + 5);
      e0 = end_cnt;
      send(3'd1, d);
      chk(nm, DW'(end_cnt - e0), DW'(b == 15));
    end
  endtask

  typedef struct {
    logic [2:0]    st;
    logic [DW-1:0] d;
    bit            has;
    logic [DW-1:0] exp;
  } row_t;

  row_t tbl [13];
  int   n0;
  int   keys [6];

  initial begin
    tbl[0]  = '{3'd2, mk(32'h0, 0, 0), 1, VM ? miss() : srv(0)};
    tbl[1]  = '{3'd3, mk(32'hDEAD, 40, 0), 1, ack1(40)};
    tbl[2]  = '{3'd3, mk(32'hDEAD, 200, 0), 1, ack1(200)};
    tbl[3]  = '{3'd2, mk(32'hDEAD, 0, 0), 1, srv(40)};
    tbl[4]  = '{3'd3, mk(32'hBEEF, 65, 0), 1, ack1(65)};
    tbl[5]  = '{3'd3, mk(32'hBEEF, 64, 0), 1, ack1(64)};
    tbl[6]  = '{3'd2, mk(32'hBEEF, 0, 0), 1, srv(64)};
    tbl[7]  = '{3'd2, mk(32'h12345, 0, 0), 1, miss()};
    tbl[8]  = '{3'd0, mk(32'hDEAD, 3, 0), 0, '0};
    tbl[9]  = '{3'd6, mk(32'hDEAD, 3, 0), 0, '0};
    tbl[10] = '{3'd2, mk(32'h0, 0, 0), 1, VM ? miss() : srv(0)};
    tbl[11] = '{3'd3, mk(32'h1111, 40, 1), 1, ack1(40)};
    tbl[12] = '{3'd2, mk(32'hDEAD, 0, 0), 1, srv(200)};

    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rst_m_tvalid", DW'(m_tvalid), '0);
    chk("rst_m_tdata", m_tdata, '0);
    chk("rst_s_tready", DW'(s_tready), DW'(1));
    step();

    for (int r = 0; r < 13; r++) begin
      n0 = out_log.size();
      send(tbl[r].st, tbl[r].d);
      idle(6);
      chk("tbl_count", DW'(out_log.size()), DW'(n0 + int'(tbl[r].has)));
      if (tbl[r].has && out_log.size() > n0)
        chk("tbl_value", out_log[n0], tbl[r].exp);
    end

    n0 = out_log.size();
    send(3'd3, mk(32'hCAFE, 255, 0));
    send(3'd2, mk(32'hCAFE, 0, 0));
    idle(6);
    chk("cafe_count", DW'(out_log.size()), DW'(n0 + 2));
    if (out_log.size() >= n0 + 2) begin
      chk("cafe_ack", out_log[n0], ack1(255));
      chk("cafe_hit", out_log[n0+1], srv(255));
      chk("cafe_gap", DW'(out_cyc[n0+1] - out_cyc[n0]), DW'(1));
    end

    n0 = out_log.size();
    bulk_load("load_end");
    send(3'd2, mk(32'd77, 0, 0));
    idle(6);
    chk("load_count", DW'(out_log.size()), DW'(n0 + 2));
    if (out_log.size() >= n0 + 2) begin
      chk("load_ack", out_log[n0], DW'(100));
      chk("load_hit77", out_log[n0+1], srv(72));
    end

    keys = '{5, 6, 7, 8, 3, 9};
    saw_low = 0;
    n0 = out_log.size();
    fork
      begin
        for (int j = 0; j < 6; j++) send(3'd2, mk(KW'(keys[j]), 0, 0));
      end
      begin
        repeat (3) @(posedge aclk);
        rdy_mode = 1;
        repeat (4) @(posedge aclk);
        rdy_mode = 0;
      end
    join
    idle(10);
    chk("bp_sready_drop", DW'(saw_low), DW'(1));
    chk("bp_count", DW'(out_log.size()), DW'(n0 + 6));
    if (out_log.size() >= n0 + 6) begin
      for (int j = 0; j < 6; j++)
        chk("bp_order", out_log[n0+j],
            keys[j] >= 5 ? srv(keys[j] - 5) : miss());
    end

    for (int b = 0; b < 7; b++) send(3'd1, rnd512());
    send(3'd2, mk(32'd5, 0, 0));
    do_reset();
    n0 = out_log.size();
    bulk_load("reload_end");
    idle(6);
    chk("reload_count", DW'(out_log.size()), DW'(n0 + 1));
    if (out_log.size() > n0) chk("reload_ack", out_log[n0], DW'(100));

    rdy_mode = 2;
    for (int it = 0; it < 700; it++) begin
      int r;
      logic [DW-1:0] d;
      r = $urandom % 10;
      d = rnd512();
      d[KW-1:0] = KW'($urandom % 64);
      if (r < 3) begin
        send(3'd2, d);
      end else if (r < 5) begin
        send(3'd3, d);
      end else if (r < 7) begin
        repeat ($urandom_range(1, 20)) begin
          for (int k = 0; k < LN; k++) d[k*KW +: KW] = KW'($urandom % 64);
          send(3'd1, d);
        end
      end else if (r == 7) begin
        idle($urandom_range(1, 3));
      end else begin
        send(3'($urandom_range(4, 7)), d);
        send(3'd0, d);
      end
    end
    rdy_mode = 0;
    idle(12);
    chk("drain_empty", DW'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
